// File: rtl/mac_operand_sequencer.sv
// Operand-pair FIFO feeding a downstream MAC stage, one dot-product vector per start pulse.
// Optional feature MAC_SEQ_ZERO_SKIP_EN: popped pairs with a zero operand count toward len but issue invalid.
module mac_operand_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_a,
  input  logic [3:0]                    in_b,
  input  logic                          start,
  input  logic [LEN_W-1:0]              vec_len,
  output logic [3:0]                    mac_a,
  output logic [3:0]                    mac_b,
  output logic                          mac_valid,
  output logic                          mac_clear,
  output logic                          vec_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       mem_a_q [FIFO_DEPTH];
  logic [3:0]       mem_b_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [3:0]       mac_a_q, mac_b_q;
  logic             mac_valid_q;
  logic             push, pop, issue;
  logic [3:0]       head_a, head_b;

  assign in_ready = rst_n && (count_q != CntW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign head_a   = mem_a_q[rd_ptr_q];
  assign head_b   = mem_b_q[rd_ptr_q];

`ifdef MAC_SEQ_ZERO_SKIP_EN
  assign issue = pop && (head_a != 4'd0) && (head_b != 4'd0);
`else
  assign issue = pop;
`endif

  // Storage is not reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClear;
          len_d   = (vec_len == '0) ? LEN_W'(1) : vec_len;
        end
      end
      StClear: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (cnt_q == len_q - LEN_W'(1)) state_d = StDone;
          else                            cnt_d   = cnt_q + LEN_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operands follow every pop; mac_valid marks which of them are to be accumulated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_valid_q <= 1'b0;
    end else begin
      mac_valid_q <= issue;
      if (pop) begin
        mac_a_q <= head_a;
        mac_b_q <= head_b;
      end
    end
  end

  assign mac_a      = mac_a_q;
  assign mac_b      = mac_b_q;
  assign mac_valid  = mac_valid_q;
  assign mac_clear  = (state_q == StClear);
  assign vec_done   = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: directed scenarios plus random traffic against a
// transaction-level model (pair queue, vector phase counter, issued-pair count).
module tb_mac_operand_sequencer;

  localparam int FD = 4;
  localparam int LW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_a;
  logic [3:0]    in_b;
  logic          start;
  logic [LW-1:0] vec_len;
  logic [3:0]    mac_a;
  logic [3:0]    mac_b;
  logic          mac_valid;
  logic          mac_clear;
  logic          vec_done;
  logic          busy;
  logic [2:0]    fifo_count;

  mac_operand_sequencer #(
    .FIFO_DEPTH (FD),
    .LEN_W      (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .start      (start),
    .vec_len    (vec_len),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_valid  (mac_valid),
    .mac_clear  (mac_clear),
    .vec_done   (vec_done),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] m_fifo[$];
  bit         m_active;
  int         m_phase;
  int         m_popped;
  int         m_len;
  bit         m_done_prev;
  logic [3:0] m_a, m_b;
  bit         m_pushed;
  int         acc;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: predict from the rules, advance, then compare every observable output.
  task automatic step();
    bit         rst_pre, do_pop, do_push, acc_start, exp_valid, exp_done;
    logic [3:0] pa, pb;
    logic [7:0] pair;
    int         vl;
    rst_pre   = !rst_n;
    do_pop    = m_active && (m_phase >= 2) && (m_popped < m_len) && (m_fifo.size() > 0);
    do_push   = in_valid && (m_fifo.size() < FD);
    acc_start = start && !m_active;
    pa        = in_a;
    pb        = in_b;
    vl        = int'(vec_len);
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    m_pushed  = 1'b0;
    if (rst_pre) begin
      m_fifo.delete();
      m_active    = 1'b0;
      m_phase     = 0;
      m_popped    = 0;
      m_len       = 0;
      m_done_prev = 1'b0;
      m_a         = '0;
      m_b         = '0;
    end else begin
      if (m_active) begin
        if (m_done_prev) m_active = 1'b0;
        else             m_phase++;
      end
      m_done_prev = 1'b0;
      if (do_pop) begin
        pair = m_fifo.pop_front();
        m_a  = pair[7:4];
        m_b  = pair[3:0];
        m_popped++;
`ifdef MAC_SEQ_ZERO_SKIP_EN
        exp_valid = (m_a != 4'd0) && (m_b != 4'd0);
`else
        exp_valid = 1'b1;
`endif
        exp_done    = (m_popped == m_len);
        m_done_prev = exp_done;
      end
      if (do_push) begin
        m_fifo.push_back({pa, pb});
        m_pushed = 1'b1;
      end
      if (acc_start) begin
        m_active = 1'b1;
        m_phase  = 1;
        m_popped = 0;
        m_len    = (vl == 0) ? 1 : vl;
      end
    end
    if (mac_clear) acc = 0;
    if (mac_valid) acc += int'(mac_a) * int'(mac_b);
    check("in_ready", in_ready, (rst_n && m_fifo.size() < FD) ? 1 : 0);
    check("fifo_count", fifo_count, m_fifo.size());
    check("mac_valid", mac_valid, exp_valid);
    check("mac_a", mac_a, m_a);
    check("mac_b", mac_b, m_b);
    check("mac_clear", mac_clear, (m_active && m_phase == 1) ? 1 : 0);
    check("vec_done", vec_done, exp_done);
    check("busy", busy, m_active);
  endtask

  task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic start_vec(input int l);
    start   = 1'b1;
    vec_len = LW'(l);
    step();
    start   = 1'b0;
  endtask

  initial begin
    m_fifo.delete();
    m_active = 0; m_phase = 0; m_popped = 0; m_len = 0; m_done_prev = 0;
    m_a = '0; m_b = '0; m_pushed = 0; acc = 0;
    rst_n = 1'b0; in_valid = 1'b1; in_a = 4'd3; in_b = 4'd5; start = 1'b0; vec_len = '0;

    // Reset held with in_valid asserted: nothing may be pushed
    repeat (2) step();
    rst_n = 1'b1; in_valid = 1'b0;
    step();

    // Basic three-pair vector, downstream sum 15+8+7
    push_pair(4'd3, 4'd5);
    push_pair(4'd2, 4'd4);
    push_pair(4'd1, 4'd7);
    start_vec(3);
    repeat (6) step();
    check("dot_sum", acc, 30);

    // Fill past capacity, then drain two and let the fifth pair in
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_a = 4'(i); in_b = 4'(i + 1);
      step();
    end
    check("full_count", fifo_count, 4);
    check("full_ready", in_ready, 0);
    start = 1'b1; vec_len = LW'(2);
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m_pushed) break;
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();

    // vec_len of zero issues exactly one pair; then drain the rest
    start_vec(0);
    repeat (5) step();
    start_vec(2);
    repeat (6) step();

    // Starvation: vector waits on an empty FIFO
    start_vec(2);
    repeat (4) step();
    push_pair(4'd6, 4'd7);
    repeat (3) step();
    push_pair(4'd8, 4'd9);
    repeat (5) step();

    // Reset after the first of four pairs is issued
    for (int i = 0; i < 4; i++) push_pair(4'(i + 2), 4'(i + 3));
    start_vec(4);
    repeat (2) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();

    // Zero-operand pair inside a vector
    push_pair(4'd0, 4'd9);
    push_pair(4'd2, 4'd3);
    start_vec(2);
    repeat (6) step();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rst_n    = ($urandom_range(0, 63) != 0);
      in_valid = $urandom_range(0, 1) != 0;
      in_a     = 4'($urandom_range(0, 15));
      in_b     = 4'($urandom_range(0, 15));
      start    = ($urandom_range(0, 5) == 0);
      vec_len  = LW'($urandom_range(0, 6));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
